// File: rtl/mem_port_arbiter_if.sv
// Request/grant, response and memory-drive signals shared by the fetch and load/store ports.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6,
    parameter int SEG_W  = 5
);
    logic              if_req;
    logic [SEG_W-1:0]  if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [WIDTH-1:0]  if_rdata;

    logic              ds_req;
    logic              ds_we;
    logic [SEG_W-1:0]  ds_addr;
    logic [WIDTH-1:0]  ds_wd;
    logic              ds_gnt;
    logic              ds_rvalid;
    logic [WIDTH-1:0]  ds_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wd;
    logic [WIDTH-1:0]  mem_rdata;

    modport slave (
        input  if_req, if_addr, ds_req, ds_we, ds_addr, ds_wd, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ds_gnt, ds_rvalid, ds_rdata,
               mem_addr, mem_we, mem_wd
    );

    modport master (
        output if_req, if_addr, ds_req, ds_we, ds_addr, ds_wd, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ds_gnt, ds_rvalid, ds_rdata,
               mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one single-ported segmented memory, data first with a starvation bound.
// Grants are same-cycle combinational; read data and rvalid arrive one cycle after the grant; losers hold req.
module mem_port_arbiter #(
    parameter int WIDTH      = 8,
    parameter int ADDR_W     = 6,
    parameter int SEG_W      = 5,
    parameter int DATA_BASE  = 32,
    parameter int MAX_STREAK = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [ADDR_W-1:0]   BASE_ADDR  = ADDR_W'(DATA_BASE);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IF   = 2'd1,
        ST_DS   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [STREAK_W-1:0] streak;
    logic                force_if;
    logic                if_gnt;
    logic                ds_gnt;
    logic [SEG_W-1:0]    if_off;
    logic [SEG_W-1:0]    ds_off;
    logic [WIDTH-1:0]    if_rdata_q;
    logic [WIDTH-1:0]    ds_rdata_q;

    assign if_off = bus.if_addr;
    assign ds_off = bus.ds_addr;

    // Grants are gated by rst_n so nothing reaches the memory while reset is held.
    always_comb begin
        force_if  = bus.if_req && (streak == STREAK_MAX);
        ds_gnt    = rst_n && bus.ds_req && !force_if;
        if_gnt    = rst_n && bus.if_req && (!bus.ds_req || force_if);
        state_nxt = ST_IDLE;
        if (if_gnt) begin
            state_nxt = ST_IF;
        end else if (ds_gnt) begin
            state_nxt = ST_DS;
        end
    end

    always_comb begin
        bus.mem_addr = '0;
        bus.mem_we   = 1'b0;
        bus.mem_wd   = '0;
        if (ds_gnt) begin
            // Addition wraps modulo the memory size.
            bus.mem_addr = BASE_ADDR + ADDR_W'(ds_off);
            bus.mem_we   = bus.ds_we;
            bus.mem_wd   = bus.ds_wd;
        end else if (if_gnt) begin
            bus.mem_addr = ADDR_W'(if_off);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (!bus.if_req || if_gnt) begin
            streak <= '0;
        end else if (ds_gnt && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
        end
    end

    // Stores acknowledge via ds_rvalid but leave the load data register untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            ds_rdata_q <= '0;
        end else begin
            if (if_gnt) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (ds_gnt && !bus.ds_we) begin
                ds_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ds_gnt    = ds_gnt;
    assign bus.if_rvalid = (state == ST_IF);
    assign bus.ds_rvalid = (state == ST_DS);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ds_rdata  = ds_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 64x8 unified memory between the instruction-fetch requester and the load/store requester.
- The memory is segmented: the instruction segment starts at 0 and the data segment starts at DATA_BASE.
- The block chooses one winner per cycle, drives the memory address, write enable and write data, translates data-segment offsets to absolute addresses, and returns registered read data with a one-cycle valid pulse.
- A streak counter bounds how long instruction fetch can be starved.

Parameters:
WIDTH, 8, data width of memory words and write data
ADDR_W, 6, absolute memory address width (64 words)
SEG_W, 5, offset width inside one segment (32 words)
DATA_BASE, 32, absolute address of data-segment word 0
MAX_STREAK, 3, maximum consecutive data grants while a fetch is pending

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request, held until if_gnt
if_addr  input  SEG_W  instruction-segment offset
if_gnt  output  1  fetch granted this cycle (combinational)
if_rvalid  output  1  one-cycle pulse, if_rdata valid
if_rdata  output  WIDTH  registered fetched word
ds_req  input  1  data request, held until ds_gnt
ds_we  input  1  1 = store, 0 = load
ds_addr  input  SEG_W  data-segment offset
ds_wd  input  WIDTH  store data
ds_gnt  output  1  data access granted this cycle (combinational)
ds_rvalid  output  1  one-cycle pulse: load data valid or store acknowledged
ds_rdata  output  WIDTH  registered loaded word
mem_addr  output  ADDR_W  absolute address to memory
mem_we  output  1  memory write enable
mem_wd  output  WIDTH  memory write data
mem_rdata  input  WIDTH  memory combinational read data

Behaviour:
- Reset (rst_n low, asynchronous)
  - Registered outputs clear: if_rvalid=0, ds_rvalid=0, if_rdata=0, ds_rdata=0, streak=0, last-grant state=IDLE.
  - While rst_n is low, if_gnt, ds_gnt and mem_we are forced to 0. Combinational gating is used so no write can occur during reset.
  - A response pending when reset asserts is discarded. No rvalid appears after reset releases.
- Arbitration (combinational, same cycle as the request)
  - Data has priority: ds_gnt = ds_req & ~force_if.
  - if_gnt = if_req & (~ds_req | force_if).
  - force_if = if_req & (streak == MAX_STREAK).
  - At most one grant per cycle.
- Memory drive
  - Data grant: mem_addr = DATA_BASE + zero-extended ds_addr, computed modulo 2^ADDR_W. mem_we = ds_we. mem_wd = ds_wd.
  - Fetch grant: mem_addr = zero-extended if_addr. mem_we = 0.
  - No grant: mem_addr = 0, mem_we = 0, mem_wd = 0.
  - The memory writes on the same posedge that ends the grant cycle.
- Response (latency 1)
  - On the posedge ending a fetch-grant cycle: if_rdata <= mem_rdata and if_rvalid pulses high for exactly one cycle.
  - On the posedge ending a data-load cycle: ds_rdata <= mem_rdata and ds_rvalid pulses for one cycle.
  - For a store, ds_rvalid still pulses, but ds_rdata holds its previous value.
  - rdata registers hold their value until the next matching read.
  - Back-to-back grants produce back-to-back rvalid pulses.
- State machine (last grant): IDLE, IF, DS.
  - The state drives which rvalid pulses in the following cycle.
  - Next state is IF on if_gnt, DS on ds_gnt, otherwise IDLE.
- Streak counter (width = clog2(MAX_STREAK+1))
  - Increments on ds_gnt while if_req is high.
  - Clears on if_gnt or when if_req is low.
  - Saturates at MAX_STREAK.
- Handshake rules
  - A requester may drop its req before being granted; no access occurs.
  - Inputs are sampled only in the grant cycle.
  - A requester keeping req high after a grant issues a new request.
- Simultaneous events
  - Both requests with streak < MAX_STREAK: data wins.
  - With streak == MAX_STREAK: fetch wins, then streak clears.

Test Plan:
- Reset values: assert rst_n=0 mid-cycle with ds_req=1, ds_we=1 -> mem_we=0 immediately; all rvalid and rdata are 0; no memory write occurs.
- Fetch latency: if_req=1, if_addr=5, memory word 5 = 0xA3 -> if_gnt=1 and mem_addr=5 in that cycle; next cycle if_rvalid=1 and if_rdata=0xA3; pulse lasts one cycle.
- Store then load: store ds_addr=2, ds_wd=0x5C -> mem_addr=34, mem_we=1; next cycle ds_rvalid=1 with ds_rdata unchanged. Then load ds_addr=2 -> ds_rdata=0x5C one cycle after its grant.
- Address wrap: ds_addr=31 -> mem_addr=63. With DATA_BASE=40 and ds_addr=30 -> mem_addr=6 (modulo 64).
- Starvation bound: if_req and ds_req held high, MAX_STREAK=3 -> grants are DS, DS, DS, IF, DS, DS, DS, IF, ... and rvalids follow each grant one cycle later.
- Request withdrawal: if_req high for one cycle while ds_req is high, then if_req drops -> no fetch grant, no if_rvalid, and streak returns to 0.
